// File: rtl/instr_fetch.sv
// Instruction fetch/decode front end: owns the PC, reads one or two words from
// synchronous memory, splits them into fields and hands them over valid/ready.
module instr_fetch #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RESET_PC   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [3:0]            oc,
  output logic                  di1,
  output logic                  di2,
  output logic                  di3,
  output logic [2:0]            a1,
  output logic [2:0]            a2,
  output logic [2:0]            a3,
  output logic                  two_word,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  halted
);

  localparam int unsigned OC_W    = 4;
  localparam logic [OC_W-1:0] OC_MOV  = 4'b0000;
  localparam logic [OC_W-1:0] OC_STOP = 4'b1111;
  localparam logic [3:0]      MOV_IMM_TAG = 4'b1000;

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_F1   = 3'd1,
    ST_W1   = 3'd2,
    ST_F2   = 3'd3,
    ST_W2   = 3'd4,
    ST_OUT  = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  load_word1;
  logic                  load_word2;
  logic                  word1_is_two;
  logic                  fetch_next;

  // A MOV whose low nibble carries the immediate tag is followed by a constant word
  assign word1_is_two = (mem_data[15:12] == OC_MOV) && (mem_data[3:0] == MOV_IMM_TAG);
  assign fetch_next   = (state_next == ST_F1) || (state_next == ST_F2);

  // Next-state and datapath-enable logic; a redirect overrides everything but reset
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_word1 = 1'b0;
    load_word2 = 1'b0;
    case (state)
      ST_RST:  state_next = ST_F1;
      ST_F1: begin
        pc_next    = pc + ADDR_WIDTH'(1);
        state_next = ST_W1;
      end
      ST_W1: begin
        load_word1 = 1'b1;
        state_next = word1_is_two ? ST_F2 : ST_OUT;
      end
      ST_F2: begin
        pc_next    = pc + ADDR_WIDTH'(1);
        state_next = ST_W2;
      end
      ST_W2: begin
        load_word2 = 1'b1;
        state_next = ST_OUT;
      end
      ST_OUT: begin
        if (dec_ready) state_next = (oc == OC_STOP) ? ST_HALT : ST_F1;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RST;
    endcase
    if (pc_load && (state != ST_RST)) begin
      pc_next    = pc_in;
      state_next = ST_F1;
      load_word1 = 1'b0;
      load_word2 = 1'b0;
    end
  end

  // State, PC and state-decoded strobes, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST;
      pc        <= ADDR_WIDTH'(RESET_PC);
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      dec_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      mem_rd    <= fetch_next;
      mem_addr  <= fetch_next ? pc_next : '0;
      dec_valid <= (state_next == ST_OUT);
      halted    <= (state_next == ST_HALT);
    end
  end

  // Decoded instruction fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc       <= '0;
      di1      <= 1'b0;
      di2      <= 1'b0;
      di3      <= 1'b0;
      a1       <= '0;
      a2       <= '0;
      a3       <= '0;
      two_word <= 1'b0;
      imm      <= '0;
    end else begin
      if (load_word1) begin
        oc       <= mem_data[15:12];
        di1      <= mem_data[11];
        a1       <= mem_data[10:8];
        di2      <= mem_data[7];
        a2       <= mem_data[6:4];
        di3      <= mem_data[3];
        a3       <= mem_data[2:0];
        two_word <= word1_is_two;
        if (!word1_is_two) imm <= '0;
      end
      if (load_word2) imm <= mem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, then random traffic checked against
// an instruction-level model of the PC and of the memory image.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        pc_load;
  logic [5:0]  pc_in;
  logic [5:0]  pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  oc;
  logic        di1, di2, di3;
  logic [2:0]  a1, a2, a3;
  logic        two_word;
  logic [15:0] imm;
  logic        halted;

  logic [15:0] mem [64];
  int          n_checks = 0;
  int          n_err    = 0;

  instr_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RESET_PC(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .pc_load(pc_load), .pc_in(pc_in), .pc(pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .oc(oc), .di1(di1), .di2(di2), .di3(di3), .a1(a1), .a2(a2), .a3(a3),
    .two_word(two_word), .imm(imm), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after the read strobe
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Instruction-level view of one instruction starting at address a
  task automatic check_instr(input string tag, input logic [5:0] a, output logic [5:0] nxt,
                             output logic is_stop);
    logic [15:0] w;
    logic [15:0] k;
    logic        tw;
    logic [5:0]  a_next;
    w      = mem[a];
    a_next = a + 6'd1;
    k      = mem[a_next];
    tw     = (w[15:12] == 4'h0) && (w[3:0] == 4'h8);
    chk({tag, ".oc"}, 32'(oc), 32'(w[15:12]));
    chk({tag, ".di"}, 32'({di1, di2, di3}), 32'({w[11], w[7], w[3]}));
    chk({tag, ".a"}, 32'({a1, a2, a3}), 32'({w[10:8], w[6:4], w[2:0]}));
    chk({tag, ".two_word"}, 32'(two_word), 32'(tw));
    chk({tag, ".imm"}, 32'(imm), tw ? 32'(k) : 32'h0);
    nxt = tw ? a + 6'd2 : a + 6'd1;
    chk({tag, ".pc"}, 32'(pc), 32'(nxt));
    is_stop = (w[15:12] == 4'hF);
  endtask

  initial begin
    logic [5:0] nxt;
    logic       stop;
    logic [5:0] exp_pc;
    logic       exp_halt;
    int         idle;
    int         accepts;
    int         halts;

    rst_n = 1'b0; pc_load = 1'b0; pc_in = '0; dec_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000;
    mem[8] = 16'h1123;
    #2;

    // Reset state
    do_reset();
    chk("rst.pc", 32'(pc), 32'd8);
    chk("rst.dec_valid", 32'(dec_valid), 32'd0);
    chk("rst.mem_rd", 32'({mem_rd, mem_addr}), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.fields", 32'({oc, a1, a2, a3, two_word}), 32'd0);

    // One-word instruction after reset
    tick();
    chk("t1.read", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'd8}));
    tick();
    chk("t1.w1_valid", 32'(dec_valid), 32'd0);
    tick();
    chk("t1.dec_valid", 32'(dec_valid), 32'd1);
    check_instr("t1", 6'd8, nxt, stop);

    // Two-word instruction
    mem[8] = 16'h0108; mem[9] = 16'h00FF; mem[10] = 16'hF000;
    dec_ready = 1'b0;
    do_reset();
    tick();
    chk("t2.read1", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'd8}));
    tick(); tick();
    chk("t2.read2", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'd9}));
    tick(); tick();
    chk("t2.dec_valid", 32'(dec_valid), 32'd1);
    check_instr("t2", 6'd8, nxt, stop);

    // Stall in OUT with dec_ready low
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3.stall", 32'({dec_valid, mem_rd, pc, imm, oc, a1, di3}),
          32'({1'b1, 1'b0, 6'd10, 16'h00FF, 4'h0, 3'd1, 1'b1}));
    end
    dec_ready = 1'b1;
    tick();
    chk("t3.next_read", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'd10}));

    // STOP halts until redirected
    tick(); tick();
    chk("t4.stop_valid", 32'({dec_valid, oc}), 32'({1'b1, 4'hF}));
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t4.halted", 32'({halted, mem_rd, dec_valid}), 32'({1'b1, 1'b0, 1'b0}));
      tick();
    end
    pc_load = 1'b1; pc_in = 6'd8;
    tick();
    pc_load = 1'b0;
    chk("t4.resume", 32'({halted, mem_rd, mem_addr}), 32'({1'b0, 1'b1, 6'd8}));

    // Two-word instruction wrapping the PC
    mem[63] = 16'h0208; mem[0] = 16'h1234; mem[1] = 16'h1123; mem[20] = 16'h2345;
    pc_load = 1'b1; pc_in = 6'd63;
    tick();
    pc_load = 1'b0;
    chk("t5.read1", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'd63}));
    tick(); tick();
    chk("t5.read2", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'd0}));
    tick(); tick();
    chk("t5.dec_valid", 32'(dec_valid), 32'd1);
    check_instr("t5", 6'd63, nxt, stop);

    // Redirect during W1 discards the in-flight word
    tick();
    chk("t6.read", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'd1}));
    tick();
    pc_load = 1'b1; pc_in = 6'd20;
    tick();
    pc_load = 1'b0;
    chk("t6.redirect", 32'({dec_valid, mem_rd, mem_addr}), 32'({1'b0, 1'b1, 6'd20}));
    tick();
    chk("t6.no_valid", 32'(dec_valid), 32'd0);
    tick();
    chk("t6.dec_valid", 32'(dec_valid), 32'd1);
    dec_ready = 1'b0;
    check_instr("t6", 6'd20, nxt, stop);

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("t7.async_rst", 32'({dec_valid, pc, oc, imm}), 32'({1'b0, 6'd8, 4'h0, 16'h0}));
    tick();

    // Random traffic against the instruction-level model
    for (int i = 0; i < 64; i++) begin
      logic [31:0] r;
      logic [15:0] w;
      r = $urandom;
      w = r[15:0];
      case (r[18:16])
        3'd0:       w = {4'hF, w[11:0]};
        3'd1, 3'd2: w = {4'h0, w[11:4], 4'h8};
        default:    ;
      endcase
      mem[i] = w;
    end
    dec_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    exp_pc = 6'd8; exp_halt = 1'b0; idle = 0; accepts = 0; halts = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("rnd.halted", 32'(halted), 32'(exp_halt));
      if (halted) chk("rnd.halt_quiet", 32'({mem_rd, dec_valid}), 32'd0);
      dec_ready = ($urandom % 4) != 0;
      pc_load   = exp_halt ? (($urandom % 4) == 0) : (($urandom % 24) == 0);
      pc_in     = 6'($urandom);
      idle++;
      if (dec_valid && dec_ready) begin
        check_instr("rnd", exp_pc, nxt, stop);
        exp_pc = nxt;
        if (stop) begin
          exp_halt = 1'b1;
          halts++;
        end
        accepts++;
        idle = 0;
      end
      if (pc_load) begin
        exp_pc   = pc_in;
        exp_halt = 1'b0;
        idle     = 0;
      end
      if (exp_halt) idle = 0;
      if (idle > 40) begin
        chk("rnd.progress", 32'(idle), 32'd0);
        idle = 0;
      end
      tick();
    end
    pc_load = 1'b0;
    chk("rnd.activity", 32'(accepts > 100 && halts > 5), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
